// File: rtl/multi_timer_pkg.sv
// Shared types and width helpers for the multi-channel timer.
package multi_timer_pkg;

  localparam int MULT_W = 3;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

  function automatic int cnt_width(input int tvalue_w);
    return tvalue_w + 7;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: counts (TVALUE<<k)-1 cycles after a trigger, pulses done on the last one.
// Periodic auto-reload exists only when MULTI_TIMER_PERIODIC_EN is defined.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int TVALUE = 7,
  parameter int CNT_W  = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tr,
  input  logic              stop,
  input  logic [MULT_W-1:0] multiplier,
  input  logic              periodic,
  output logic              cf,
  output logic              done
);

  localparam logic [CNT_W-1:0] TV = CNT_W'(TVALUE);

  function automatic logic [CNT_W-1:0] reload_val(input logic [MULT_W-1:0] k);
    return (TV << k) - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef MULTI_TIMER_PERIODIC_EN
  logic [MULT_W-1:0] mult_q, mult_d;
  mode_e             mode_q, mode_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_q <= '0;
      mode_q <= MODE_ONESHOT;
    end else begin
      mult_q <= mult_d;
      mode_q <= mode_d;
    end
  end
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
`endif

  always_comb begin
    cnt_d = cnt_q;
`ifdef MULTI_TIMER_PERIODIC_EN
    mult_d = mult_q;
    mode_d = mode_q;
`endif
    // stop outranks both a fresh trigger and a periodic reload
    if (stop) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      if (tr) begin
        cnt_d = reload_val(multiplier);
`ifdef MULTI_TIMER_PERIODIC_EN
        mult_d = multiplier;
        mode_d = periodic ? MODE_PERIODIC : MODE_ONESHOT;
`endif
      end
    end else if (cnt_q == CNT_W'(1)) begin
`ifdef MULTI_TIMER_PERIODIC_EN
      cnt_d = (mode_q == MODE_PERIODIC) ? reload_val(mult_q) : '0;
`else
      cnt_d = '0;
`endif
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cf   = (cnt_q == '0);
  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/multi_timer.sv
// Array of independent timer channels sharing only clock and reset.
// Optional feature macro: MULTI_TIMER_PERIODIC_EN (periodic auto-reload mode).
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int TVALUE   = 7,
  parameter int TVALUE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CHANNELS-1:0]        tr,
  input  logic [CHANNELS-1:0]        stop,
  input  logic [MULT_W*CHANNELS-1:0] multiplier,
  input  logic [CHANNELS-1:0]        periodic,
  output logic [CHANNELS-1:0]        cf,
  output logic [CHANNELS-1:0]        done
);

  localparam int CNT_W = cnt_width(TVALUE_W);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      timer_channel #(
        .TVALUE(TVALUE),
        .CNT_W (CNT_W)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .tr        (tr[gi]),
        .stop      (stop[gi]),
        .multiplier(multiplier[MULT_W*gi +: MULT_W]),
        .periodic  (periodic[gi]),
        .cf        (cf[gi]),
        .done      (done[gi])
      );
    end
  endgenerate

endmodule
